// File: rtl/fsm_1_rx_if.sv
// rtl/fsm_1_rx_if.sv - serial sample input and status outputs of the pattern checker
interface fsm_1_rx_if #(
  parameter int CNT_W = 16
) ();
  logic             in;
  logic             in_en;
  logic             locked;
  logic             match;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] period_count;

  modport master (
    output in, in_en,
    input  locked, match, err, err_count, period_count
  );

  modport slave (
    input  in, in_en,
    output locked, match, err, err_count, period_count
  );
endinterface

// File: rtl/fsm_1_rx.sv
// rtl/fsm_1_rx.sv - serial pattern checker: hunt, confirm, then track a LEN-bit pattern
// Counters saturate and survive loss of lock; only rst clears them.
module fsm_1_rx #(
  parameter int             LEN      = 4,
  parameter logic [LEN-1:0] PATTERN  = 4'b1100,
  parameter int             LOCK_CNT = 2,
  parameter int             ERR_MAX  = 3,
  parameter int             CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  fsm_1_rx_if.slave   bus
);

  localparam int FW = $clog2(LEN + 1);
  localparam int PW = $clog2(LEN);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [LEN-1:0]   hist, hist_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic [CW-1:0]    conf, conf_nxt;
  logic [EW-1:0]    cerr, cerr_nxt;
  logic             perr, perr_nxt;
  logic             locked_q, locked_nxt;
  logic             match_q, match_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] err_cnt, err_cnt_nxt;
  logic [CNT_W-1:0] per_cnt, per_cnt_nxt;

  logic [LEN-1:0]   nh;
  logic [LEN-1:0]   pat_sh;
  logic             bit_ok;
  logic             last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HUNT;
      hist     <= '0;
      fill     <= '0;
      phase    <= '0;
      conf     <= '0;
      cerr     <= '0;
      perr     <= 1'b0;
      locked_q <= 1'b0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      per_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      phase    <= phase_nxt;
      conf     <= conf_nxt;
      cerr     <= cerr_nxt;
      perr     <= perr_nxt;
      locked_q <= locked_nxt;
      match_q  <= match_nxt;
      err_q    <= err_nxt;
      err_cnt  <= err_cnt_nxt;
      per_cnt  <= per_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hist_nxt    = hist;
    fill_nxt    = fill;
    phase_nxt   = phase;
    conf_nxt    = conf;
    cerr_nxt    = cerr;
    perr_nxt    = perr;
    match_nxt   = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    per_cnt_nxt = per_cnt;

    nh     = {hist[LEN-2:0], bus.in};
    // Expected bit is selected by shifting the pattern so the current phase sits at the MSB.
    pat_sh = PATTERN << phase;
    bit_ok = (bus.in == pat_sh[LEN-1]);
    last   = (phase == PW'(LEN - 1));

    if (bus.in_en) begin
      hist_nxt = nh;
      fill_nxt = (fill == FW'(LEN)) ? fill : fill + 1'b1;
      case (state)
        HUNT: begin
          if (fill >= FW'(LEN - 1) && nh == PATTERN) begin
            phase_nxt = '0;
            conf_nxt  = CW'(1);
            cerr_nxt  = '0;
            perr_nxt  = 1'b0;
            state_nxt = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (!bit_ok) begin
            state_nxt = HUNT;
            fill_nxt  = '0;
          end else if (last) begin
            phase_nxt = '0;
            conf_nxt  = conf + 1'b1;
            if (conf + 1'b1 == CW'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              cerr_nxt  = '0;
              perr_nxt  = 1'b0;
            end
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
        LOCKED: begin
          phase_nxt = last ? '0 : phase + 1'b1;
          perr_nxt  = last ? 1'b0 : (perr | ~bit_ok);
          if (!bit_ok) begin
            err_nxt = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + 1'b1;
            if (cerr + 1'b1 == EW'(ERR_MAX)) begin
              state_nxt = HUNT;
              fill_nxt  = '0;
              cerr_nxt  = '0;
            end else begin
              cerr_nxt = cerr + 1'b1;
            end
          end else begin
            cerr_nxt = '0;
            if (last && !perr) begin
              match_nxt = 1'b1;
              if (per_cnt != '1) per_cnt_nxt = per_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  assign bus.locked       = locked_q;
  assign bus.match        = match_q;
  assign bus.err          = err_q;
  assign bus.err_count    = err_cnt;
  assign bus.period_count = per_cnt;

endmodule
